// File: rtl/pipe_ctrl_dec.sv
// pipe_ctrl_dec: main control decoder for the pipelined RV32I core, plus the D->E->M->W
// control pipeline. Each control field is carried only as far as the stage that uses it.
//
// Parameters
//   EXT_EN    1: also decode lui/auipc/jalr; 0: base set only
//   IMMSRC_W  width of ImmSrcD (3 with EXT_EN=1; 2 allowed with EXT_EN=0)
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opD                 instruction[6:0] in Decode
//   StallE, FlushE      hazard-unit controls for the E register
//   ImmSrcD, IllegalD   combinational decode outputs
//   ALUSrcAE ... IllegalE  Execute-stage controls
//   MemWriteM, RegWriteM   Memory-stage controls
//   ResultSrcW, RegWriteW  Writeback-stage controls
module pipe_ctrl_dec #(
  parameter bit          EXT_EN   = 1'b1,
  parameter int unsigned IMMSRC_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opD,
  input  logic                StallE,
  input  logic                FlushE,
  output logic [IMMSRC_W-1:0] ImmSrcD,
  output logic                IllegalD,
  output logic                ALUSrcAE,
  output logic                ALUSrcBE,
  output logic [1:0]          ALUOpE,
  output logic                BranchE,
  output logic                JumpE,
  output logic                JumpRegE,
  output logic                ResultSrcE0,
  output logic                IllegalE,
  output logic                MemWriteM,
  output logic                RegWriteM,
  output logic [1:0]          ResultSrcW,
  output logic                RegWriteW
);

  // Fields that travel into Execute. An all-zero value is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jump_reg;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  ctrl_e_t    ctrl_d;
  logic [2:0] imm_src_full;
  ctrl_e_t    ctrl_e;
  ctrl_m_t    ctrl_m;
  ctrl_w_t    ctrl_w;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d       = '0;
    imm_src_full = 3'b000;
    unique case (opD)
      7'b0000011: begin // lw
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src_b  = 1'b1;
        ctrl_d.result_src = 2'b01;
      end
      7'b0100011: begin // sw
        imm_src_full      = 3'b001;
        ctrl_d.alu_src_b  = 1'b1;
        ctrl_d.mem_write  = 1'b1;
      end
      7'b0110011: begin // R-type
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_op     = 2'b10;
      end
      7'b1100011: begin // B-type
        imm_src_full      = 3'b010;
        ctrl_d.branch     = 1'b1;
        ctrl_d.alu_op     = 2'b01;
      end
      7'b0010011: begin // I-type ALU
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src_b  = 1'b1;
        ctrl_d.alu_op     = 2'b10;
      end
      7'b1101111: begin // jal
        ctrl_d.reg_write  = 1'b1;
        imm_src_full      = 3'b011;
        ctrl_d.result_src = 2'b10;
        ctrl_d.jump       = 1'b1;
      end
      7'b0110111: begin // lui
        if (EXT_EN) begin
          ctrl_d.reg_write  = 1'b1;
          imm_src_full      = 3'b100;
          ctrl_d.alu_src_b  = 1'b1;
          ctrl_d.result_src = 2'b11;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      7'b0010111: begin // auipc
        if (EXT_EN) begin
          ctrl_d.reg_write  = 1'b1;
          imm_src_full      = 3'b100;
          ctrl_d.alu_src_a  = 1'b1;
          ctrl_d.alu_src_b  = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      7'b1100111: begin // jalr
        if (EXT_EN) begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.alu_src_b  = 1'b1;
          ctrl_d.result_src = 2'b10;
          ctrl_d.jump       = 1'b1;
          ctrl_d.jump_reg   = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // Narrow ImmSrc builds keep only the low bits of the table encoding.
  assign ImmSrcD  = imm_src_full[IMMSRC_W-1:0];
  assign IllegalD = ctrl_d.illegal;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      // Flush wins over stall so a squashed instruction never lingers in E.
      if (FlushE) begin
        ctrl_e <= '0;
      end else if (!StallE) begin
        ctrl_e <= ctrl_d;
      end

      // While E is held its instruction must not also advance into M.
      if (StallE) begin
        ctrl_m <= '0;
      end else begin
        ctrl_m.reg_write  <= ctrl_e.reg_write;
        ctrl_m.mem_write  <= ctrl_e.mem_write;
        ctrl_m.result_src <= ctrl_e.result_src;
      end

      ctrl_w.reg_write  <= ctrl_m.reg_write;
      ctrl_w.result_src <= ctrl_m.result_src;
    end
  end

  assign ALUSrcAE    = ctrl_e.alu_src_a;
  assign ALUSrcBE    = ctrl_e.alu_src_b;
  assign ALUOpE      = ctrl_e.alu_op;
  assign BranchE     = ctrl_e.branch;
  assign JumpE       = ctrl_e.jump;
  assign JumpRegE    = ctrl_e.jump_reg;
  assign ResultSrcE0 = ctrl_e.result_src[0];
  assign IllegalE    = ctrl_e.illegal;
  assign MemWriteM   = ctrl_m.mem_write;
  assign RegWriteM   = ctrl_m.reg_write;
  assign ResultSrcW  = ctrl_w.result_src;
  assign RegWriteW   = ctrl_w.reg_write;

endmodule

// File: tb/tb_pipe_ctrl_dec.sv
// tb_pipe_ctrl_dec: drives two instances (full decode, 3-bit ImmSrc; base decode, 2-bit
// ImmSrc) with identical stimulus and compares every output against a table-driven model.
module tb_pipe_ctrl_dec;

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  logic       clk;
  logic       reset;
  logic [6:0] opD;
  logic       StallE;
  logic       FlushE;

  // dut0: EXT_EN=1, IMMSRC_W=3
  logic [2:0] ImmSrcD0;
  logic       IllegalD0, ALUSrcAE0, ALUSrcBE0, BranchE0, JumpE0, JumpRegE0;
  logic       ResultSrcE00, IllegalE0, MemWriteM0, RegWriteM0, RegWriteW0;
  logic [1:0] ALUOpE0, ResultSrcW0;
  // dut1: EXT_EN=0, IMMSRC_W=2
  logic [1:0] ImmSrcD1;
  logic       IllegalD1, ALUSrcAE1, ALUSrcBE1, BranchE1, JumpE1, JumpRegE1;
  logic       ResultSrcE01, IllegalE1, MemWriteM1, RegWriteM1, RegWriteW1;
  logic [1:0] ALUOpE1, ResultSrcW1;

  pipe_ctrl_dec #(.EXT_EN(1'b1), .IMMSRC_W(3)) u_dut0 (
    .clk(clk), .reset(reset), .opD(opD), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD0), .IllegalD(IllegalD0), .ALUSrcAE(ALUSrcAE0), .ALUSrcBE(ALUSrcBE0),
    .ALUOpE(ALUOpE0), .BranchE(BranchE0), .JumpE(JumpE0), .JumpRegE(JumpRegE0),
    .ResultSrcE0(ResultSrcE00), .IllegalE(IllegalE0), .MemWriteM(MemWriteM0),
    .RegWriteM(RegWriteM0), .ResultSrcW(ResultSrcW0), .RegWriteW(RegWriteW0)
  );

  pipe_ctrl_dec #(.EXT_EN(1'b0), .IMMSRC_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .opD(opD), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD1), .IllegalD(IllegalD1), .ALUSrcAE(ALUSrcAE1), .ALUSrcBE(ALUSrcBE1),
    .ALUOpE(ALUOpE1), .BranchE(BranchE1), .JumpE(JumpE1), .JumpRegE(JumpRegE1),
    .ResultSrcE0(ResultSrcE01), .IllegalE(IllegalE1), .MemWriteM(MemWriteM1),
    .RegWriteM(RegWriteM1), .ResultSrcW(ResultSrcW1), .RegWriteW(RegWriteW1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {RW, ImmSrc[2:0], SrcA, SrcB, MW, RS[1:0], Br, ALUOp[1:0], J, JR, Illegal}.
  function automatic logic [14:0] ref_dec(input logic [6:0] op, input bit ext);
    logic [13:0] c;
    logic        ill;
    c   = '0;
    ill = 1'b0;
    case (op)
      OpLw:    c = 14'b1_000_0_1_0_01_0_00_0_0;
      OpSw:    c = 14'b0_001_0_1_1_00_0_00_0_0;
      OpR:     c = 14'b1_000_0_0_0_00_0_10_0_0;
      OpB:     c = 14'b0_010_0_0_0_00_1_01_0_0;
      OpI:     c = 14'b1_000_0_1_0_00_0_10_0_0;
      OpJal:   c = 14'b1_011_0_0_0_10_0_00_1_0;
      OpLui:   if (ext) c = 14'b1_100_0_1_0_11_0_00_0_0; else ill = 1'b1;
      OpAuipc: if (ext) c = 14'b1_100_1_1_0_00_0_00_0_0; else ill = 1'b1;
      OpJalr:  if (ext) c = 14'b1_000_0_1_0_10_0_00_1_1; else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    return {c, ill};
  endfunction

  // Model state per instance: E {ref_dec format}, M {RW, MW, RS}, W {RW, RS}.
  logic [14:0] me [2];
  logic [3:0]  mm [2];
  logic [2:0]  mw [2];

  // Expected {E: SrcA,SrcB,ALUOp,Br,J,JR,RS0,Ill | M: MW,RW | W: RS,RW}.
  function automatic logic [13:0] pack_exp(input logic [14:0] e, input logic [3:0] m,
                                           input logic [2:0] w);
    return {e[10], e[9], e[4:3], e[5], e[2], e[1], e[6], e[0], m[2], m[3], w[1:0], w[2]};
  endfunction

  logic [13:0] sb_q0[$];
  logic [13:0] sb_q1[$];

  function automatic logic [13:0] dut_regs(input int idx);
    if (idx == 0)
      return {ALUSrcAE0, ALUSrcBE0, ALUOpE0, BranchE0, JumpE0, JumpRegE0, ResultSrcE00,
              IllegalE0, MemWriteM0, RegWriteM0, ResultSrcW0, RegWriteW0};
    return {ALUSrcAE1, ALUSrcBE1, ALUOpE1, BranchE1, JumpE1, JumpRegE1, ResultSrcE01,
            IllegalE1, MemWriteM1, RegWriteM1, ResultSrcW1, RegWriteW1};
  endfunction

  task automatic check_regs(input int idx, input logic [13:0] exp);
    logic [13:0] got;
    got = dut_regs(idx);
    check_eq($sformatf("d%0d.E", idx), {23'd0, got[13:5]}, {23'd0, exp[13:5]});
    check_eq($sformatf("d%0d.M", idx), {30'd0, got[4:3]}, {30'd0, exp[4:3]});
    check_eq($sformatf("d%0d.W", idx), {29'd0, got[2:0]}, {29'd0, exp[2:0]});
  endtask

  task automatic check_comb();
    logic [14:0] r;
    r = ref_dec(opD, 1'b1);
    check_eq("d0.ImmSrcD", {29'd0, ImmSrcD0}, {29'd0, r[13:11]});
    check_eq("d0.IllegalD", {31'd0, IllegalD0}, {31'd0, r[0]});
    r = ref_dec(opD, 1'b0);
    check_eq("d1.ImmSrcD", {30'd0, ImmSrcD1}, {30'd0, r[12:11]});
    check_eq("d1.IllegalD", {31'd0, IllegalD1}, {31'd0, r[0]});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      me[i] = '0;
      mm[i] = '0;
      mw[i] = '0;
    end
  endtask

  // Advance the model over the coming edge, queue expectations, then compare after the edge.
  task automatic edge_and_check();
    logic [14:0] ne;
    logic [3:0]  nm;
    logic [2:0]  nw;
    logic [13:0] exp;
    for (int i = 0; i < 2; i++) begin
      ne = FlushE ? 15'd0 : (StallE ? me[i] : ref_dec(opD, i == 0));
      nm = StallE ? 4'd0 : {me[i][14], me[i][8], me[i][7:6]};
      nw = {mm[i][3], mm[i][1:0]};
      me[i] = ne;
      mm[i] = nm;
      mw[i] = nw;
      if (i == 0) sb_q0.push_back(pack_exp(ne, nm, nw));
      else        sb_q1.push_back(pack_exp(ne, nm, nw));
    end
    @(posedge clk);
    #1;
    if (sb_q0.size() == 0 || sb_q1.size() == 0) begin
      check_eq("sb.empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q0.pop_front();
      check_regs(0, exp);
      exp = sb_q1.pop_front();
      check_regs(1, exp);
    end
  endtask

  task automatic step(input logic [6:0] op, input logic stall, input logic flush);
    @(negedge clk);
    opD    = op;
    StallE = stall;
    FlushE = flush;
    #1;
    check_comb();
    edge_and_check();
  endtask

  // Reset pulse between edges while stall and flush are both asserted.
  task automatic reset_mid();
    @(negedge clk);
    opD    = OpJal;
    StallE = 1'b1;
    FlushE = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_regs(0, 14'd0);
    check_regs(1, 14'd0);
    check_comb();
    #1;
    reset = 1'b0;
    edge_and_check();
  endtask

  logic [6:0] op_tbl [11];

  initial begin
    op_tbl = '{OpLw, OpSw, OpR, OpB, OpI, OpJal, OpLui, OpAuipc, OpJalr, 7'b0000000,
               7'b1111111};
    reset  = 1'b1;
    opD    = 7'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    model_clear();
    #3;
    check_regs(0, 14'd0);
    check_regs(1, 14'd0);
    #4;
    reset = 1'b0;

    // Load flows through E, M, W.
    step(OpLw, 1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);

    // Store squashed on its load edge.
    step(OpSw, 1'b0, 1'b1);
    step(OpB,  1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);

    // R-type held by a two-cycle stall.
    step(OpR,  1'b0, 1'b0);
    step(OpR,  1'b1, 1'b0);
    step(OpR,  1'b1, 1'b0);
    step(OpSw, 1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);

    // Extended opcodes.
    step(OpLui,   1'b0, 1'b0);
    step(OpAuipc, 1'b0, 1'b0);
    step(OpJalr,  1'b0, 1'b0);
    step(OpB,     1'b0, 1'b0);
    step(OpB,     1'b0, 1'b0);

    // Illegal opcodes.
    step(OpLui,      1'b0, 1'b0);
    step(7'b0000000, 1'b0, 1'b0);
    step(OpB,        1'b0, 1'b0);
    step(OpB,        1'b0, 1'b0);

    // Reset mid-pipeline, then normal decode resumes.
    step(OpLw, 1'b0, 1'b0);
    step(OpR,  1'b0, 1'b0);
    reset_mid();
    step(OpLw, 1'b0, 1'b0);
    step(OpI,  1'b0, 1'b0);
    step(OpJal, 1'b0, 1'b0);
    step(OpB,  1'b0, 1'b0);

    // Random mix with occasional stall/flush.
    for (int k = 0; k < 80; k++) begin
      step(op_tbl[$urandom_range(10, 0)], ($urandom_range(4, 0) == 0),
           ($urandom_range(5, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
